// File: rtl/hazard_sequencer.sv
// -----------------------------------------------------------------------------
// hazard_sequencer
//
// Hazard and stall controller for a 5-stage MIPS pipeline. Each cycle it
// decides whether PC and IF/ID hold, whether IF/ID or ID/EX is bubbled, and
// when the multi-cycle mult/div unit is started. It covers the dependencies
// the forwarding network cannot resolve:
//   - load-use,
//   - jr after a producer,
//   - HI/LO busy.
// It also flushes the front end on taken branches resolved in EX.
// Saturating stall and flush counters are kept for performance debug.
//
// Parameters:
//   MUL_CYCLES  EX occupancy of mult/multu in cycles (>= 2)
//   DIV_CYCLES  EX occupancy of div/divu in cycles (>= 2)
//   CNT_W       width of the performance counters
//
// Ports:
//   clk, reset             core clock; synchronous active-high reset
//   ID_*                   decode of the instruction currently in ID
//   IDEX_*                 writeback info of the instruction in EX
//   EXMEM_*                writeback info of the instruction in MEM
//                          (MemtoReg: 00 ALU, 01 mem, 10 PC+4)
//   EX_BranchTaken         branch in EX resolved taken this cycle
//   PC_Write, IFID_Write   pipeline-front write enables
//   IFID_Flush, IDEX_Flush load a nop / bubble into IF/ID, ID/EX
//   MD_Start               one-cycle start pulse for the mult/div unit
//   MD_Busy                mult/div unit occupied
//   StallCount, FlushCount saturating performance counters
//   dbg_state              current mult/div FSM state (0 idle, 1 busy)
//
// Handshake with the mult/div unit: MD_Start is a single-cycle command with
// no ready; the unit is assumed to accept it whenever it is asserted. This is
// safe because a start is issued only from IDLE or in the final busy cycle.
//
// All control outputs are combinational from the inputs and current state.
// -----------------------------------------------------------------------------
module hazard_sequencer #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic             ID_IsJr,
    input  logic             ID_IsJump,
    input  logic             ID_IsMulDiv,
    input  logic             ID_IsDiv,
    input  logic             ID_ReadsHiLo,
    input  logic             IDEX_RegWrite,
    input  logic [4:0]       IDEX_WriteRegister,
    input  logic [1:0]       IDEX_MemtoReg,
    input  logic             EXMEM_RegWrite,
    input  logic [4:0]       EXMEM_WriteRegister,
    input  logic [1:0]       EXMEM_MemtoReg,
    input  logic             EX_BranchTaken,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             MD_Start,
    output logic             MD_Busy,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount,
    output logic             dbg_state
);

    // The down-counter must hold the larger of the two reload values.
    localparam int MAX_CYC = (DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    // A started operation occupies the unit for the start cycle plus
    // (N-1) busy cycles. A dependent instruction therefore reaches EX exactly
    // as the result becomes available.
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] WB_MEM = 2'b01;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    md_state_t      state;
    logic [CW-1:0]  cnt;

    // ------------------------------------------------------------------
    // Dependency detection
    // ------------------------------------------------------------------
    logic idex_hit_rs;
    logic idex_hit_rt;
    logic exmem_hit_rs;
    logic load_use;
    logic jr_haz;
    logic md_haz;
    logic stall;
    logic busy;
    logic last_busy;
    logic md_start;
    logic stall_inc;
    logic flush_inc;

    // jr/jalr read rs even when the generic decode does not flag it.
    always_comb begin
        idex_hit_rs  = IDEX_RegWrite && (IDEX_WriteRegister != 5'd0) &&
                       (IDEX_WriteRegister == ID_Rs) && (ID_UsesRs || ID_IsJr);
        idex_hit_rt  = IDEX_RegWrite && (IDEX_WriteRegister != 5'd0) &&
                       (IDEX_WriteRegister == ID_Rt) && ID_UsesRt;
        exmem_hit_rs = EXMEM_RegWrite && (EXMEM_WriteRegister != 5'd0) &&
                       (EXMEM_WriteRegister == ID_Rs) && (ID_UsesRs || ID_IsJr);
    end

    always_comb begin
        busy      = (state == MD_BUSY);
        last_busy = busy && (cnt == CNT_ONE);

        load_use  = (idex_hit_rs || idex_hit_rt) && (IDEX_MemtoReg == WB_MEM);

        // jr resolves in ID and only sees forwarded values from the
        // EXMEM ALU/PC+4 path and from MEMWB. Any producer still in EX, or
        // a load still in MEM, must be waited out.
        jr_haz    = ID_IsJr &&
                    (idex_hit_rs || (exmem_hit_rs && (EXMEM_MemtoReg == WB_MEM)));

        // In the last busy cycle the dependent instruction may advance.
        md_haz    = (ID_IsMulDiv || ID_ReadsHiLo) && busy && (cnt > CNT_ONE);

        stall     = load_use || jr_haz || md_haz;

        // A branch in EX squashes the mult/div in ID, so it must not start.
        // In BUSY, a non-stalled mult/div can only occur when cnt == 1. That
        // gives a back-to-back restart with no idle gap.
        md_start  = !reset && ID_IsMulDiv && !stall && !EX_BranchTaken &&
                    (!busy || last_busy);

        stall_inc = !reset && !EX_BranchTaken && stall;
        flush_inc = !reset && (EX_BranchTaken || (ID_IsJump && !stall));
    end

    // ------------------------------------------------------------------
    // Pipeline control outputs (priority: reset, branch, stall, jump)
    // ------------------------------------------------------------------
    always_comb begin
        PC_Write   = 1'b1;
        IFID_Write = 1'b1;
        IFID_Flush = 1'b0;
        IDEX_Flush = 1'b0;
        if (reset || EX_BranchTaken) begin
            IFID_Flush = 1'b1;
            IDEX_Flush = 1'b1;
        end else if (stall) begin
            PC_Write   = 1'b0;
            IFID_Write = 1'b0;
            IDEX_Flush = 1'b1;
        end else if (ID_IsJump) begin
            IFID_Flush = 1'b1;
        end
    end

    always_comb begin
        MD_Start  = md_start;
        MD_Busy   = busy && !reset;
        dbg_state = state;
    end

    // ------------------------------------------------------------------
    // Mult/div occupancy FSM
    // ------------------------------------------------------------------
    // A taken branch does not abort BUSY. The mult/div in the unit is older
    // than the branch and must complete.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else if (md_start) begin
            state <= MD_BUSY;
            cnt   <= ID_IsDiv ? DIV_LOAD : MUL_LOAD;
        end else if (state == MD_BUSY) begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
                state <= MD_IDLE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (stall_inc && (StallCount != {CNT_W{1'b1}})) begin
                StallCount <= StallCount + CNT_W'(1);
            end
            if (flush_inc && (FlushCount != {CNT_W{1'b1}})) begin
                FlushCount <= FlushCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hazard_sequencer
//
// Combinational cases come from a table. Multi-cycle behaviour (load-use and
// jr stalls, divide/HI-LO wait, back-to-back mult, counter saturation, reset
// during BUSY) uses hand-written sequences.
//
// Expected output flags are pushed to a queue when the stimulus is driven.
// They are popped and compared on the falling edge. The flag vector is
// {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, MD_Start, MD_Busy}.
// -----------------------------------------------------------------------------
module tb_hazard_sequencer;

    localparam int CNT_W = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [4:0]       ID_Rs, ID_Rt;
    logic             ID_UsesRs, ID_UsesRt, ID_IsJr, ID_IsJump;
    logic             ID_IsMulDiv, ID_IsDiv, ID_ReadsHiLo;
    logic             IDEX_RegWrite;
    logic [4:0]       IDEX_WriteRegister;
    logic [1:0]       IDEX_MemtoReg;
    logic             EXMEM_RegWrite;
    logic [4:0]       EXMEM_WriteRegister;
    logic [1:0]       EXMEM_MemtoReg;
    logic             EX_BranchTaken;
    logic             PC_Write, IFID_Write, IFID_Flush, IDEX_Flush;
    logic             MD_Start, MD_Busy;
    logic [CNT_W-1:0] StallCount, FlushCount;
    logic             dbg_state;

    hazard_sequencer #(
        .MUL_CYCLES(4),
        .DIV_CYCLES(32),
        .CNT_W     (CNT_W)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .ID_Rs               (ID_Rs),
        .ID_Rt               (ID_Rt),
        .ID_UsesRs           (ID_UsesRs),
        .ID_UsesRt           (ID_UsesRt),
        .ID_IsJr             (ID_IsJr),
        .ID_IsJump           (ID_IsJump),
        .ID_IsMulDiv         (ID_IsMulDiv),
        .ID_IsDiv            (ID_IsDiv),
        .ID_ReadsHiLo        (ID_ReadsHiLo),
        .IDEX_RegWrite       (IDEX_RegWrite),
        .IDEX_WriteRegister  (IDEX_WriteRegister),
        .IDEX_MemtoReg       (IDEX_MemtoReg),
        .EXMEM_RegWrite      (EXMEM_RegWrite),
        .EXMEM_WriteRegister (EXMEM_WriteRegister),
        .EXMEM_MemtoReg      (EXMEM_MemtoReg),
        .EX_BranchTaken      (EX_BranchTaken),
        .PC_Write            (PC_Write),
        .IFID_Write          (IFID_Write),
        .IFID_Flush          (IFID_Flush),
        .IDEX_Flush          (IDEX_Flush),
        .MD_Start            (MD_Start),
        .MD_Busy             (MD_Busy),
        .StallCount          (StallCount),
        .FlushCount          (FlushCount),
        .dbg_state           (dbg_state)
    );

    // Expected flag patterns {pc_w, ifid_w, ifid_fl, idex_fl, start, busy}
    localparam logic [5:0] O_NORM  = 6'b110000;
    localparam logic [5:0] O_STALL = 6'b000100;
    localparam logic [5:0] O_BR    = 6'b111100;
    localparam logic [5:0] O_JMP   = 6'b111000;
    localparam logic [5:0] O_RST   = 6'b111100;
    localparam logic [5:0] B_START = 6'b000010;
    localparam logic [5:0] B_BUSY  = 6'b000001;

    // ID flag bundle {uses_rs, uses_rt, is_jr, is_jump, is_md, is_div, reads_hilo}
    localparam logic [6:0] F_NONE = 7'b0000000;
    localparam logic [6:0] F_RS   = 7'b1000000;
    localparam logic [6:0] F_RT   = 7'b0100000;
    localparam logic [6:0] F_JR   = 7'b0010000;
    localparam logic [6:0] F_J    = 7'b0001000;
    localparam logic [6:0] F_MD   = 7'b0000100;
    localparam logic [6:0] F_DIV  = 7'b0000010;
    localparam logic [6:0] F_HL   = 7'b0000001;

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [6:0] idf;
        logic       idex_rw;
        logic [4:0] idex_wr;
        logic [1:0] idex_m2r;
        logic       exm_rw;
        logic [4:0] exm_wr;
        logic [1:0] exm_m2r;
        logic       br;
        logic [5:0] exp;
    } vec_t;

    // ---------------- scoreboard ----------------
    logic [5:0] exp_q[$];
    string      name_q[$];
    int         checks = 0;
    int         errors = 0;

    // ---------------- driver tasks ----------------
    task automatic clear_in();
        ID_Rs = 5'd0; ID_Rt = 5'd0;
        ID_UsesRs = 1'b0; ID_UsesRt = 1'b0; ID_IsJr = 1'b0; ID_IsJump = 1'b0;
        ID_IsMulDiv = 1'b0; ID_IsDiv = 1'b0; ID_ReadsHiLo = 1'b0;
        IDEX_RegWrite = 1'b0; IDEX_WriteRegister = 5'd0; IDEX_MemtoReg = 2'b00;
        EXMEM_RegWrite = 1'b0; EXMEM_WriteRegister = 5'd0; EXMEM_MemtoReg = 2'b00;
        EX_BranchTaken = 1'b0;
    endtask

    task automatic set_id(input logic [6:0] f);
        {ID_UsesRs, ID_UsesRt, ID_IsJr, ID_IsJump, ID_IsMulDiv, ID_IsDiv, ID_ReadsHiLo} = f;
    endtask

    task automatic apply_vec(input vec_t v);
        ID_Rs = v.rs; ID_Rt = v.rt;
        set_id(v.idf);
        IDEX_RegWrite = v.idex_rw; IDEX_WriteRegister = v.idex_wr; IDEX_MemtoReg = v.idex_m2r;
        EXMEM_RegWrite = v.exm_rw; EXMEM_WriteRegister = v.exm_wr; EXMEM_MemtoReg = v.exm_m2r;
        EX_BranchTaken = v.br;
    endtask

    // Inputs are already driven; push the expectation, compare it on the
    // falling edge, then return just after the next rising edge.
    task automatic step(input string name, input logic [5:0] exp);
        logic [5:0] got;
        logic [5:0] e;
        string      n;
        exp_q.push_back(exp);
        name_q.push_back(name);
        @(negedge clk);
        got = {PC_Write, IFID_Write, IFID_Flush, IDEX_Flush, MD_Start, MD_Busy};
        e   = exp_q.pop_front();
        n   = name_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: flags got %b expected %b", n, got, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string name, input int es, input int ef);
        logic [CNT_W-1:0] xs;
        logic [CNT_W-1:0] xf;
        xs = es[CNT_W-1:0];
        xf = ef[CNT_W-1:0];
        checks++;
        if (StallCount !== xs) begin
            errors++;
            $display("FAIL %s stall_count: got %0d expected %0d", name, StallCount, xs);
        end
        checks++;
        if (FlushCount !== xf) begin
            errors++;
            $display("FAIL %s flush_count: got %0d expected %0d", name, FlushCount, xf);
        end
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1'b1;
        step("reset_flags", O_RST);
        reset = 1'b0;
        check_cnt("after_reset", 0, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test ----------------
    vec_t vecs[20];

    initial begin
        vecs[0]  = '{"idle",           5'd0, 5'd0, F_NONE,      1'b0, 5'd0, 2'b00, 1'b0, 5'd0, 2'b00, 1'b0, O_NORM};
        vecs[1]  = '{"lu_rs",          5'd8, 5'd0, F_RS,        1'b1, 5'd8, 2'b01, 1'b0, 5'd0, 2'b00, 1'b0, O_STALL};
        vecs[2]  = '{"lu_rt",          5'd3, 5'd8, F_RT,        1'b1, 5'd8, 2'b01, 1'b0, 5'd0, 2'b00, 1'b0, O_STALL};
        vecs[3]  = '{"rt_not_used",    5'd3, 5'd8, F_RS,        1'b1, 5'd8, 2'b01, 1'b0, 5'd0, 2'b00, 1'b0, O_NORM};
        vecs[4]  = '{"ex_alu_fwd",     5'd8, 5'd0, F_RS,        1'b1, 5'd8, 2'b00, 1'b0, 5'd0, 2'b00, 1'b0, O_NORM};
        vecs[5]  = '{"lu_r0",          5'd0, 5'd0, F_RS | F_RT, 1'b1, 5'd0, 2'b01, 1'b0, 5'd0, 2'b00, 1'b0, O_NORM};
        vecs[6]  = '{"lu_no_write",    5'd8, 5'd0, F_RS,        1'b0, 5'd8, 2'b01, 1'b0, 5'd0, 2'b00, 1'b0, O_NORM};
        vecs[7]  = '{"jr_ex_alu",      5'd9, 5'd0, F_RS | F_JR, 1'b1, 5'd9, 2'b00, 1'b0, 5'd0, 2'b00, 1'b0, O_STALL};
        vecs[8]  = '{"jr_mem_load",    5'd9, 5'd0, F_RS | F_JR, 1'b0, 5'd0, 2'b00, 1'b1, 5'd9, 2'b01, 1'b0, O_STALL};
        vecs[9]  = '{"jr_mem_alu",     5'd9, 5'd0, F_RS | F_JR, 1'b0, 5'd0, 2'b00, 1'b1, 5'd9, 2'b00, 1'b0, O_NORM};
        vecs[10] = '{"jr_mem_pc4",     5'd9, 5'd0, F_RS | F_JR, 1'b0, 5'd0, 2'b00, 1'b1, 5'd9, 2'b10, 1'b0, O_NORM};
        vecs[11] = '{"jr_ex_pc4_impl", 5'd9, 5'd0, F_JR,        1'b1, 5'd9, 2'b10, 1'b0, 5'd0, 2'b00, 1'b0, O_STALL};
        vecs[12] = '{"mem_load_nonjr", 5'd9, 5'd0, F_RS,        1'b0, 5'd0, 2'b00, 1'b1, 5'd9, 2'b01, 1'b0, O_NORM};
        vecs[13] = '{"jump",           5'd0, 5'd0, F_J,         1'b0, 5'd0, 2'b00, 1'b0, 5'd0, 2'b00, 1'b0, O_JMP};
        vecs[14] = '{"jump_lu",        5'd8, 5'd0, F_RS | F_J,  1'b1, 5'd8, 2'b01, 1'b0, 5'd0, 2'b00, 1'b0, O_STALL};
        vecs[15] = '{"br_lu",          5'd8, 5'd0, F_RS,        1'b1, 5'd8, 2'b01, 1'b0, 5'd0, 2'b00, 1'b1, O_BR};
        vecs[16] = '{"br_jump",        5'd0, 5'd0, F_J,         1'b0, 5'd0, 2'b00, 1'b0, 5'd0, 2'b00, 1'b1, O_BR};
        vecs[17] = '{"br_only",        5'd0, 5'd0, F_NONE,      1'b0, 5'd0, 2'b00, 1'b0, 5'd0, 2'b00, 1'b1, O_BR};
        vecs[18] = '{"hilo_idle",      5'd0, 5'd0, F_HL,        1'b0, 5'd0, 2'b00, 1'b0, 5'd0, 2'b00, 1'b0, O_NORM};
        vecs[19] = '{"jr_r0",          5'd0, 5'd0, F_RS | F_JR, 1'b1, 5'd0, 2'b00, 1'b0, 5'd0, 2'b00, 1'b0, O_NORM};

        clear_in();
        reset = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // Table: stalls at 1,2,7,8,11,14 (6); flushes at 13,15,16,17 (4).
        foreach (vecs[i]) begin
            apply_vec(vecs[i]);
            step(vecs[i].name, vecs[i].exp);
        end
        clear_in();
        check_cnt("table", 6, 4);

        // Load-use: a single stall cycle, then the add advances.
        do_reset();
        ID_Rs = 5'd8; set_id(F_RS);
        IDEX_RegWrite = 1'b1; IDEX_WriteRegister = 5'd8; IDEX_MemtoReg = 2'b01;
        step("lu_seq_stall", O_STALL);
        check_cnt("lu_seq", 1, 0);
        IDEX_RegWrite = 1'b0; IDEX_WriteRegister = 5'd0; IDEX_MemtoReg = 2'b00;
        step("lu_seq_advance", O_NORM);
        check_cnt("lu_seq_after", 1, 0);

        // jr after lw: stall in EX, stall again in MEM, then advance.
        do_reset();
        ID_Rs = 5'd9; set_id(F_RS | F_JR);
        IDEX_RegWrite = 1'b1; IDEX_WriteRegister = 5'd9; IDEX_MemtoReg = 2'b01;
        step("jr_seq_ex", O_STALL);
        IDEX_RegWrite = 1'b0; IDEX_WriteRegister = 5'd0; IDEX_MemtoReg = 2'b00;
        EXMEM_RegWrite = 1'b1; EXMEM_WriteRegister = 5'd9; EXMEM_MemtoReg = 2'b01;
        step("jr_seq_mem", O_STALL);
        EXMEM_RegWrite = 1'b0; EXMEM_WriteRegister = 5'd0; EXMEM_MemtoReg = 2'b00;
        step("jr_seq_go", O_NORM);
        check_cnt("jr_seq", 2, 0);

        // Branch beats load-use; a mult/div squashed by the branch must not start.
        do_reset();
        ID_Rs = 5'd8; set_id(F_RS | F_MD);
        IDEX_RegWrite = 1'b1; IDEX_WriteRegister = 5'd8; IDEX_MemtoReg = 2'b01;
        EX_BranchTaken = 1'b1;
        step("br_over_lu", O_BR);
        check_cnt("br_over_lu", 0, 1);
        clear_in();
        step("br_no_md", O_NORM);

        // div then mflo: 30 stalled busy cycles, mflo advances at cnt==1.
        do_reset();
        set_id(F_MD | F_DIV);
        step("div_start", O_NORM | B_START);
        set_id(F_HL);
        for (int c = 1; c <= 30; c++) begin
            step($sformatf("mflo_wait_%0d", c), O_STALL | B_BUSY);
        end
        step("mflo_go", O_NORM | B_BUSY);
        clear_in();
        step("div_done", O_NORM);
        check_cnt("div_sat", 15, 0);

        // Back-to-back mult; a branch during BUSY does not abort it.
        do_reset();
        set_id(F_MD);
        step("mul1_start", O_NORM | B_START);
        step("mul2_wait_a", O_STALL | B_BUSY);
        step("mul2_wait_b", O_STALL | B_BUSY);
        step("mul2_start", O_NORM | B_START | B_BUSY);
        clear_in();
        EX_BranchTaken = 1'b1;
        step("mul2_busy_br", O_BR | B_BUSY);
        EX_BranchTaken = 1'b0;
        step("mul2_busy_b", O_NORM | B_BUSY);
        step("mul2_busy_c", O_NORM | B_BUSY);
        step("mul2_idle", O_NORM);
        check_cnt("mul_seq", 2, 1);

        // Held load-use for 20 cycles: counter saturates at 15.
        do_reset();
        ID_Rt = 5'd4; set_id(F_RT);
        IDEX_RegWrite = 1'b1; IDEX_WriteRegister = 5'd4; IDEX_MemtoReg = 2'b01;
        for (int c = 0; c < 20; c++) begin
            step($sformatf("hold_stall_%0d", c), O_STALL);
        end
        check_cnt("hold_sat", 15, 0);

        // Reset mid-BUSY, with a mult/div still presented in ID.
        do_reset();
        set_id(F_MD | F_DIV);
        step("rb_div_start", O_NORM | B_START);
        set_id(F_HL);
        step("rb_wait_a", O_STALL | B_BUSY);
        step("rb_wait_b", O_STALL | B_BUSY);
        EX_BranchTaken = 1'b1;
        step("rb_branch", O_BR | B_BUSY);
        check_cnt("rb_before", 2, 1);
        EX_BranchTaken = 1'b0;
        set_id(F_MD);
        reset = 1'b1;
        step("rb_in_reset", O_RST);
        reset = 1'b0;
        clear_in();
        step("rb_after", O_NORM);
        check_cnt("rb_after", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
